stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl.sv | 165 ++++++++++++++++
 tb/tb_stack_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// Stack controller sequencing push / pop / top-of-stack accesses to an external
// single-port RAM with registered read data; keeps sticky error flags.
module stack_ctrl #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic              tos_i,
   input  logic [DATA_W-1:0] din_i,
   input  logic              clr_err_i,
   output logic              ready_o,
   output logic [DATA_W-1:0] dout_o,
   output logic              dout_valid_o,
   output logic [ADDR_W:0]   sp_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              overflow_o,
   output logic              underflow_o,
   output logic              cmd_err_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   output logic              ram_we_o,
   output logic              ram_re_o,
   input  logic [DATA_W-1:0] ram_rdata_i
);

   localparam int unsigned SP_W = ADDR_W + 1;
   localparam logic [SP_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PUSH     = 3'd1,
      S_POP_RD   = 3'd2,
      S_POP_WAIT = 3'd3,
      S_TOS_RD   = 3'd4,
      S_TOS_WAIT = 3'd5
   } state_e;

   state_e            state_q, state_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dout_valid_q, dout_valid_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              cmd_err_q, cmd_err_d;

   logic [1:0] n_cmd;
   logic       idle, single, any_cmd, empty, full;
   logic       acc_push, acc_pop, acc_tos;
   logic       ovf_evt, udf_evt, cerr_evt;

   // Command decode: only a lone command in IDLE can execute.
   always_comb begin
      n_cmd    = 2'(push_i) + 2'(pop_i) + 2'(tos_i);
      idle     = (state_q == S_IDLE);
      any_cmd  = (n_cmd != 2'd0);
      single   = (n_cmd == 2'd1);
      empty    = (sp_q == '0);
      full     = (sp_q == DEPTH);
      acc_push = idle & single & push_i & ~full;
      acc_pop  = idle & single & pop_i  & ~empty;
      acc_tos  = idle & single & tos_i  & ~empty;
      ovf_evt  = idle & single & push_i & full;
      udf_evt  = idle & single & (pop_i | tos_i) & empty;
      cerr_evt = any_cmd & (~idle | ~single);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (acc_push)     state_d = S_PUSH;
            else if (acc_pop) state_d = S_POP_RD;
            else if (acc_tos) state_d = S_TOS_RD;
         end
         S_PUSH:     state_d = S_IDLE;
         S_POP_RD:   state_d = S_POP_WAIT;
         S_POP_WAIT: state_d = S_IDLE;
         S_TOS_RD:   state_d = S_TOS_WAIT;
         S_TOS_WAIT: state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   // RAM strobes decode straight from state so a reset drops them at once.
   always_comb begin
      ram_we_o    = 1'b0;
      ram_re_o    = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      unique case (state_q)
         S_PUSH: begin
            ram_we_o    = 1'b1;
            ram_addr_o  = sp_q[ADDR_W-1:0];
            ram_wdata_o = din_q;
         end
         S_POP_RD, S_TOS_RD: begin
            ram_re_o   = 1'b1;
            ram_addr_o = ADDR_W'(sp_q - SP_W'(1));
         end
         default: ;
      endcase
   end

   always_comb begin
      sp_d         = sp_q;
      din_d        = din_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      if (acc_push) din_d = din_i;
      unique case (state_q)
         S_PUSH:   sp_d = sp_q + SP_W'(1);
         S_POP_RD: sp_d = sp_q - SP_W'(1);
         S_POP_WAIT, S_TOS_WAIT: begin
            dout_d       = ram_rdata_i;
            dout_valid_d = 1'b1;
         end
         default: ;
      endcase
      // A same-cycle error event beats the clear.
      overflow_d  = (overflow_q  & ~clr_err_i) | ovf_evt;
      underflow_d = (underflow_q & ~clr_err_i) | udf_evt;
      cmd_err_d   = (cmd_err_q   & ~clr_err_i) | cerr_evt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sp_q         <= '0;
         din_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
         cmd_err_q    <= 1'b0;
      end else begin
         sp_q         <= sp_d;
         din_q        <= din_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
         cmd_err_q    <= cmd_err_d;
      end
   end

   assign ready_o      = idle;
   assign dout_o       = dout_q;
   assign dout_valid_o = dout_valid_q;
   assign sp_o         = sp_q;
   assign empty_o      = empty;
   assign full_o       = full;
   assign overflow_o   = overflow_q;
   assign underflow_o  = underflow_q;
   assign cmd_err_o    = cmd_err_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: queue-based stack model checked every cycle, a RAM
// model with registered read, directed scenarios and randomized traffic.
module tb_stack_ctrl;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              push_i = 1'b0, pop_i = 1'b0, tos_i = 1'b0, clr_err_i = 1'b0;
   logic [DATA_W-1:0] din_i = '0;
   logic              ready_o, dout_valid_o, empty_o, full_o;
   logic              overflow_o, underflow_o, cmd_err_o, ram_we_o, ram_re_o;
   logic [DATA_W-1:0] dout_o, ram_wdata_o;
   logic [ADDR_W:0]   sp_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic [DATA_W-1:0] ram_rdata = '0;

   int checks = 0;
   int errors = 0;

   stack_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .push_i(push_i), .pop_i(pop_i), .tos_i(tos_i),
      .din_i(din_i), .clr_err_i(clr_err_i), .ready_o(ready_o), .dout_o(dout_o),
      .dout_valid_o(dout_valid_o), .sp_o(sp_o), .empty_o(empty_o), .full_o(full_o),
      .overflow_o(overflow_o), .underflow_o(underflow_o), .cmd_err_o(cmd_err_o),
      .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_we_o(ram_we_o),
      .ram_re_o(ram_re_o), .ram_rdata_i(ram_rdata)
   );

   always #5 clk = ~clk;

   // External RAM with one-cycle registered read
   logic [DATA_W-1:0] mem [DEPTH];
   initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
   always @(posedge clk) begin
      if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
      if (ram_re_o) ram_rdata <= mem[ram_addr_o];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: stack as a queue, an in-flight operation as a countdown.
   logic [DATA_W-1:0] stk [$];
   int                m_left = 0;    // cycles the block is still busy
   int                m_op   = 0;    // 1 push, 2 pop, 3 tos
   logic [DATA_W-1:0] m_din = '0, m_val = '0, m_dout = '0;
   bit                m_dv = 0, m_ovf = 0, m_udf = 0, m_cerr = 0;

   always @(posedge clk or posedge rst) begin : model
      int  n;
      bit  eo, eu, ec;
      if (rst) begin
         stk.delete();
         m_left = 0; m_op = 0; m_din = '0; m_dout = '0;
         m_dv = 0; m_ovf = 0; m_udf = 0; m_cerr = 0;
      end else begin
         n  = int'(push_i) + int'(pop_i) + int'(tos_i);
         eo = 0; eu = 0; ec = 0;
         m_dv = 0;
         if (m_left == 0) begin
            if (n > 1) ec = 1;
            else if (push_i) begin
               if (stk.size() == DEPTH) eo = 1;
               else begin m_op = 1; m_left = 1; m_din = din_i; end
            end else if (pop_i || tos_i) begin
               if (stk.size() == 0) eu = 1;
               else begin m_op = pop_i ? 2 : 3; m_left = 2; end
            end
         end else begin
            if (n > 0) ec = 1;
            if (m_op == 1) begin
               stk.push_back(m_din);
               m_left = 0;
            end else if (m_left == 2) begin
               m_val = stk[$];
               if (m_op == 2) void'(stk.pop_back());
               m_left = 1;
            end else begin
               m_dout = m_val;
               m_dv   = 1;
               m_left = 0;
            end
         end
         m_ovf  = (m_ovf  && !clr_err_i) || eo;
         m_udf  = (m_udf  && !clr_err_i) || eu;
         m_cerr = (m_cerr && !clr_err_i) || ec;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin : compare
      bit                 e_we, e_re;
      logic [ADDR_W-1:0]  e_addr;
      logic [DATA_W-1:0]  e_wd;
      if (!rst) begin
         e_we   = (m_op == 1) && (m_left == 1);
         e_re   = (m_op >= 2) && (m_left == 2);
         e_addr = e_we ? ADDR_W'(stk.size()) : e_re ? ADDR_W'(stk.size() - 1) : '0;
         e_wd   = e_we ? m_din : '0;
         chk("ready",     32'(ready_o),      32'(m_left == 0));
         chk("sp",        32'(sp_o),         32'(stk.size()));
         chk("empty",     32'(empty_o),      32'(stk.size() == 0));
         chk("full",      32'(full_o),       32'(stk.size() == DEPTH));
         chk("dout",      32'(dout_o),       32'(m_dout));
         chk("dout_valid",32'(dout_valid_o), 32'(m_dv));
         chk("overflow",  32'(overflow_o),   32'(m_ovf));
         chk("underflow", 32'(underflow_o),  32'(m_udf));
         chk("cmd_err",   32'(cmd_err_o),    32'(m_cerr));
         chk("ram_we",    32'(ram_we_o),     32'(e_we));
         chk("ram_re",    32'(ram_re_o),     32'(e_re));
         chk("ram_addr",  32'(ram_addr_o),   32'(e_addr));
         chk("ram_wdata", 32'(ram_wdata_o),  32'(e_wd));
      end
   end

   // Logs for the directed checks: returned data, busy-run lengths, strobe counts
   logic [DATA_W-1:0] dv_log [$];
   int                busy_log [$];
   int                busy_run = 0, we_cnt = 0, re_cnt = 0;
   always @(negedge clk) begin
      if (rst) busy_run = 0;
      else begin
         if (dout_valid_o) dv_log.push_back(dout_o);
         if (ram_we_o) we_cnt++;
         if (ram_re_o) re_cnt++;
         if (!ready_o) busy_run++;
         else if (busy_run > 0) begin busy_log.push_back(busy_run); busy_run = 0; end
      end
   end

   task automatic drive(input bit p, input bit po, input bit t, input bit c,
                        input logic [DATA_W-1:0] d);
      push_i = p; pop_i = po; tos_i = t; clr_err_i = c; din_i = d;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!ready_o && k < 10) begin tick(); k++; end
      chk("wait_ready", 32'(ready_o), 32'd1);
   endtask

   task automatic cmd(input bit p, input bit po, input bit t, input logic [DATA_W-1:0] d);
      wait_ready();
      drive(p, po, t, 1'b0, d);
      tick();
      drive(0, 0, 0, 0, '0);
   endtask

   task automatic clr();
      drive(0, 0, 0, 1, '0);
      tick();
      drive(0, 0, 0, 0, '0);
   endtask

   task automatic settle();
      repeat (4) tick();
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int w0, pw, pp;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      // Reset values
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_sp",    32'(sp_o),    32'd0);
      chk("rst_empty", 32'(empty_o), 32'd1);
      chk("rst_dout",  32'(dout_o),  32'd0);
      chk("rst_flags", {29'd0, overflow_o, underflow_o, cmd_err_o}, 32'd0);

      // Pop on empty stack
      cmd(0, 1, 0, '0);
      settle();
      chk("udf_flag",  32'(underflow_o), 32'd1);
      chk("udf_no_re", 32'(re_cnt),      32'd0);
      chk("udf_dout",  32'(dout_o),      32'h00);
      clr();
      chk("udf_clr",   32'(underflow_o), 32'd0);

      // LIFO order
      cmd(1, 0, 0, 8'h11); cmd(1, 0, 0, 8'h22); cmd(1, 0, 0, 8'h33);
      settle();
      chk("lifo_sp3", 32'(sp_o), 32'd3);
      dv_log.delete();
      repeat (3) cmd(0, 1, 0, '0);
      settle();
      chk("lifo_n",  32'(dv_log.size()), 32'd3);
      chk("lifo_d0", 32'(dv_log[0]), 32'h33);
      chk("lifo_d1", 32'(dv_log[1]), 32'h22);
      chk("lifo_d2", 32'(dv_log[2]), 32'h11);
      chk("lifo_empty", {30'd0, empty_o, 1'b0} | 32'(sp_o), 32'd2);
      chk("lifo_flags", {29'd0, overflow_o, underflow_o, cmd_err_o}, 32'd0);

      // tos leaves the stack alone; busy runs after the accepting cycle
      dv_log.delete(); busy_log.delete();
      cmd(1, 0, 0, 8'h7E); cmd(0, 0, 1, '0); cmd(0, 0, 1, '0);
      settle();
      chk("tos_n",   32'(dv_log.size()), 32'd2);
      chk("tos_d0",  32'(dv_log[0]), 32'h7E);
      chk("tos_d1",  32'(dv_log[1]), 32'h7E);
      chk("tos_sp",  32'(sp_o), 32'd1);
      chk("busy_n",  32'(busy_log.size()), 32'd3);
      chk("busy_push", 32'(busy_log[0]), 32'd1);
      chk("busy_tos",  32'(busy_log[1]), 32'd2);
      busy_log.delete();
      cmd(0, 1, 0, '0);
      settle();
      chk("busy_pop", 32'(busy_log[0]), 32'd2);

      // Simultaneous commands, then a push during POP_WAIT
      cmd(1, 0, 0, 8'h44);
      settle();
      cmd(1, 1, 0, 8'h55);
      settle();
      chk("multi_err", 32'(cmd_err_o), 32'd1);
      chk("multi_sp",  32'(sp_o),      32'd1);
      clr();
      dv_log.delete();
      cmd(0, 1, 0, '0);          // now in POP_RD
      tick();                    // now in POP_WAIT
      drive(1, 0, 0, 0, 8'h66);
      tick();
      drive(0, 0, 0, 0, '0);
      settle();
      chk("busy_err",  32'(cmd_err_o), 32'd1);
      chk("busy_dout", 32'(dout_o),    32'h44);
      chk("busy_sp",   32'(sp_o),      32'd0);
      chk("busy_dvn",  32'(dv_log.size()), 32'd1);
      clr();

      // Fill to full, overflow, tos at full
      for (int i = 0; i < DEPTH; i++) cmd(1, 0, 0, 8'(i));
      settle();
      chk("full_sp",   32'(sp_o),   32'd16);
      chk("full_flag", 32'(full_o), 32'd1);
      w0 = we_cnt;
      cmd(1, 0, 0, 8'hAA);
      settle();
      chk("ovf_flag",  32'(overflow_o), 32'd1);
      chk("ovf_no_we", 32'(we_cnt - w0), 32'd0);
      chk("ovf_sp",    32'(sp_o), 32'd16);
      cmd(0, 0, 1, '0);
      settle();
      chk("full_tos",  32'(dout_o), 32'h0F);
      chk("full_tos_sp", 32'(sp_o), 32'd16);

      // Reset in the middle of a push
      rst = 1'b1; tick(); rst = 1'b0; tick();
      cmd(1, 0, 0, 8'h5A);       // now in PUSH
      chk("pre_rst_we", 32'(ram_we_o), 32'd1);
      rst = 1'b1;
      #1;
      chk("arst_we",    32'(ram_we_o), 32'd0);
      chk("arst_sp",    32'(sp_o),     32'd0);
      chk("arst_ready", 32'(ready_o),  32'd1);
      chk("arst_out",   {22'd0, dout_o, dout_valid_o, overflow_o}, 32'd0);
      tick();
      rst = 1'b0;
      cmd(1, 0, 0, 8'h12);
      settle();
      chk("post_rst_sp", 32'(sp_o), 32'd1);

      // Randomized traffic, alternating fill and drain bias
      for (int i = 0; i < 3000; i++) begin
         pw = ((i / 250) % 2 == 0) ? 45 : 15;
         pp = ((i / 250) % 2 == 0) ? 20 : 45;
         if ($urandom_range(0, 299) == 0) begin
            drive(0, 0, 0, 0, '0);
            rst = 1'b1; tick(); rst = 1'b0;
         end else begin
            drive($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pp,
                  $urandom_range(0, 99) < 8, $urandom_range(0, 19) == 0,
                  8'($urandom));
            tick();
         end
      end
      drive(0, 0, 0, 0, '0);
      settle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
